// File: rtl/fetch_pkg.sv
// Shared widths, constants and the prefetch queue entry type for the fetch front-end.
package fetch_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, inst} entries; pointers carry an extra wrap bit for full/empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW:0]   wr_ptr_q;
    logic [PW:0]   rd_ptr_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (PW + 1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (PW + 1)'(1);
        end
    end

    // Storage needs no reset: entries are only read once the pointers say they are valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_q[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: sequential PC generation, credit-limited requests, prefetch
// queue towards the core, and redirect handling that drops stale in-flight responses.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [ADDR_W-1:0] redirect_base;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]     q_count;
    logic [CW:0]       in_use;
    logic              started_q;
    logic              req_fire;
    logic              keep_rsp;
    logic              pop;
    logic              q_full;
    logic              q_empty;
    fetch_entry_t      q_head;
    fetch_entry_t      push_entry;

    assign redirect_base = redirect_pc & ~ADDR_W'(3);

    // Slots already spoken for: live in-flight requests plus buffered entries.
    assign in_use = {1'b0, outstanding_q} - {1'b0, drop_cnt_q} + {1'b0, q_count};

    assign imem_req_valid = started_q && !redirect_valid && (in_use < CAP);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign keep_rsp       = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
    assign push_entry     = '{pc: rsp_pc_q, inst: imem_rsp_data};

    assign inst_valid = !q_empty && !redirect_valid;
    assign pop        = inst_valid && inst_ready;
    assign inst       = inst_valid ? q_head.inst : NOP_INST;
    assign inst_pc    = inst_valid ? q_head.pc : '0;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;

        if (req_fire)       outstanding_d = outstanding_d + CW'(1);
        if (imem_rsp_valid) outstanding_d = outstanding_d - CW'(1);

        if (redirect_valid) begin
            fetch_pc_d = redirect_base;
            rsp_pc_d   = redirect_base;
            drop_cnt_d = outstanding_d;
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            if (keep_rsp) rsp_pc_d = rsp_pc_q + ADDR_W'(4);
            if (imem_rsp_valid && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            started_q     <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            started_q     <= 1'b1;
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clock    (clock),
        .reset    (reset),
        .flush    (redirect_valid),
        .push     (keep_rsp),
        .push_data(push_entry),
        .pop      (pop),
        .head     (q_head),
        .count    (q_count),
        .full     (q_full),
        .empty    (q_empty)
    );

    // Credits should make this impossible; a hit means the accounting is broken.
    assert property (@(posedge clock) disable iff (!reset) !(keep_rsp && q_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: memory model, stream reference model and scoreboard.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    fetch_unit #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    exp_t        exp_q[$];
    mreq_t       mem_q[$];
    logic [31:0] exp_fetch_pc = RESET_PC;
    int          cyc = 0;
    int          last_due = 0;
    int          req_cnt = 0;
    int          deliv_cnt = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    int unsigned pct_req_ready  = 100;
    int unsigned pct_inst_ready = 100;
    int unsigned pct_redir      = 0;
    int unsigned lat_min        = 1;
    int unsigned lat_max        = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // In-order memory, latency >= 1, one response per cycle, returns addr + 0x100.
    always @(posedge clock) begin
        cyc++;
        #1;
        if (!reset) begin
            imem_rsp_valid = 1'b0;
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_q[0].addr + 32'h100;
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    end

    // Reference model + scoreboard: expected stream is fetch_pc, +4, ... restarted on redirect.
    always @(negedge clock) begin
        if (reset) begin
            if (redirect_valid) begin
                check("req_valid_during_redirect", {31'b0, imem_req_valid}, 32'd0);
                check("inst_valid_during_redirect", {31'b0, inst_valid}, 32'd0);
                exp_q.delete();
                exp_fetch_pc = redirect_pc & ~32'h3;
            end else begin
                if (imem_req_valid && imem_req_ready) begin
                    int d;
                    check("req_addr", imem_req_addr, exp_fetch_pc);
                    exp_q.push_back('{pc: exp_fetch_pc, inst: exp_fetch_pc + 32'h100});
                    exp_fetch_pc = exp_fetch_pc + 32'd4;
                    req_cnt++;
                    d = cyc + int'($urandom_range(lat_max, lat_min));
                    if (d <= last_due) d = last_due + 1;
                    last_due = d;
                    mem_q.push_back('{addr: imem_req_addr, due: d});
                end
                if (inst_valid && inst_ready) begin
                    deliv_cnt++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_inst: got pc %h inst %h, expected none",
                                 inst_pc, inst);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("inst_pc", inst_pc, e.pc);
                        check("inst", inst, e.inst);
                    end
                end
            end
            if (!inst_valid) begin
                check("idle_inst_nop", inst, NOP_INST);
                check("idle_inst_pc", inst_pc, 32'd0);
            end
        end
    end

    task automatic step(input bit force_redir, input logic [31:0] rpc);
        @(posedge clock);
        #1;
        imem_req_ready = ($urandom_range(99) < pct_req_ready);
        inst_ready     = ($urandom_range(99) < pct_inst_ready);
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = rpc;
        end else begin
            redirect_valid = ($urandom_range(99) < pct_redir);
            redirect_pc    = $urandom;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0);
    endtask

    task automatic clear_model();
        exp_q.delete();
        mem_q.delete();
        last_due     = 0;
        req_cnt      = 0;
        exp_fetch_pc = RESET_PC;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
        check({tag, "_inst_valid"}, {31'b0, inst_valid}, 32'd0);
        check({tag, "_inst"}, inst, NOP_INST);
        check({tag, "_inst_pc"}, inst_pc, 32'd0);
        check({tag, "_req_addr"}, imem_req_addr, RESET_PC);
    endtask

    initial begin
        int          base;
        logic [31:0] held;
        bit          hit;

        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");

        // Fresh stream with a stalled core: credits cap requests at DEPTH.
        pct_inst_ready = 0;
        inst_ready     = 1'b0;
        imem_req_ready = 1'b1;
        reset          = 1'b1;
        #1;
        check("not_started_req_valid", {31'b0, imem_req_valid}, 32'd0);
        @(posedge clock);
        #1;
        check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, RESET_PC);
        run(12);
        #1;
        check("credit_cap_reqs", req_cnt, DEPTH);
        check("credit_cap_valid", {31'b0, imem_req_valid}, 32'd0);
        check("credit_cap_addr", imem_req_addr, RESET_PC + 32'h10);

        // Sustained one instruction per cycle with 1-cycle memory.
        pct_inst_ready = 100;
        run(10);
        base = deliv_cnt;
        run(30);
        check("throughput", deliv_cnt - base, 30);

        // Memory stalls: address must hold.
        pct_req_ready = 0;
        step(1'b0, 32'd0);
        held = imem_req_addr;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd0);
            check("stall_req_valid", {31'b0, imem_req_valid}, 32'd1);
            check("stall_addr_stable", imem_req_addr, held);
        end
        pct_req_ready = 100;
        run(6);

        // Redirect with responses in flight on a 3-cycle memory.
        lat_min = 3;
        lat_max = 3;
        run(8);
        step(1'b1, 32'h200);
        run(12);

        // Redirect coinciding with a response, then a second redirect one cycle later.
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step(1'b0, 32'd0);
            #1;
            if (imem_rsp_valid) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h180;
                hit            = 1'b1;
            end
        end
        check("redirect_on_rsp_found", {31'b0, hit}, 32'd1);
        step(1'b1, 32'h300);
        base = deliv_cnt;
        run(15);
        check("post_redirect_delivers", {31'b0, (deliv_cnt > base)}, 32'd1);

        // Random traffic.
        lat_min        = 1;
        lat_max        = 4;
        pct_req_ready  = 70;
        pct_inst_ready = 70;
        pct_redir      = 5;
        run(3000);

        // Reset mid-stream with a non-empty queue.
        pct_redir      = 0;
        pct_req_ready  = 100;
        pct_inst_ready = 0;
        lat_min        = 1;
        lat_max        = 1;
        run(6);
        #1;
        check("pre_reset_inst_valid", {31'b0, inst_valid}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        clear_model();
        redirect_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset          = 1'b1;
        pct_inst_ready = 100;
        inst_ready     = 1'b1;
        base           = deliv_cnt;
        run(20);
        check("restart_delivers", {31'b0, (deliv_cnt > base)}, 32'd1);

        // Drain: stop requests and let everything in flight reach the core.
        pct_req_ready = 0;
        for (int i = 0; i < 100 && (exp_q.size() > 0 || mem_q.size() > 0); i++) run(1);
        run(2);
        check("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
